// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down_counter block.
package down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a one-cycle done pulse.
// Define DOWN_COUNTER_RELOAD_EN to restart from the last loaded value after DONE.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] out_n;
`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload, reload_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            out    <= '0;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state  <= state_n;
            out    <= out_n;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload <= reload_n;
`endif
        end
    end

    // Load wins in every state; a zero load parks in IDLE without a done pulse.
    always_comb begin
        state_n  = state;
        out_n    = out;
`ifdef DOWN_COUNTER_RELOAD_EN
        reload_n = reload;
`endif
        if (load) begin
            out_n   = load_value;
            state_n = (load_value != '0) ? RUN : IDLE;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_n = load_value;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                RUN: begin
                    if (enable) begin
                        if (out > WIDTH'(1)) begin
                            out_n = out - WIDTH'(1);
                        end else begin
                            out_n   = '0;
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
`ifdef DOWN_COUNTER_RELOAD_EN
                    if (reload != '0) begin
                        out_n   = reload;
                        state_n = RUN;
                    end else begin
                        out_n   = '0;
                        state_n = IDLE;
                    end
`else
                    out_n   = '0;
                    state_n = IDLE;
`endif
                end
                default: begin
                    out_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign zero = (out == '0);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter; directed vectors plus a per-cycle reference model.
module tb_down_counter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] out;
    logic         busy;
    logic         zero;
    logic         done;

    int n_chk = 0;
    int n_err = 0;

    down_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .out        (out),
        .busy       (busy),
        .zero       (zero),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining count plus "counting" / "just finished" flags.
    int m_out    = 0;
    int m_reload = 0;
    bit m_busy   = 1'b0;
    bit m_done   = 1'b0;
    bit m_valid  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_out = 0; m_reload = 0; m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (load) begin
                m_out    = int'(load_value);
                m_reload = int'(load_value);
                m_busy   = (load_value != 0);
                m_done   = 1'b0;
            end else if (m_done) begin
                m_done = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
                m_out  = m_reload;
                m_busy = (m_reload != 0);
`else
                m_out  = 0;
                m_busy = 1'b0;
`endif
            end else if (m_busy && enable) begin
                m_out = m_out - 1;
                if (m_out == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("model_out",  32'(out),  32'(m_out));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_zero", 32'(zero), 32'(m_out == 0));
        end
    end

    task automatic cyc(input bit r, input bit l, input logic [W-1:0] v, input bit e);
        @(negedge clk);
        reset = r; load = l; load_value = v; enable = e;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_o(input string tag, input int o, input bit b, input bit d);
        chk({tag, "_out"},  32'(out),  32'(o));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; load = 1'b1; load_value = 8'h55; enable = 1'b0;
        // Reset beats a simultaneous load for two cycles
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp_o("rst", 0, 1'b0, 1'b0);
            chk("rst_zero", 32'(zero), 32'd1);
        end

        // Load 5, count down continuously
        cyc(0, 1, 8'd5, 1'b1); exp_o("c5_load", 5, 1'b1, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            cyc(0, 0, 8'd0, 1'b1); exp_o("c5_dec", i, 1'b1, 1'b0);
        end
        cyc(0, 0, 8'd0, 1'b1); exp_o("c5_done", 0, 1'b0, 1'b1);
        cyc(0, 0, 8'd0, 1'b1);
`ifdef DOWN_COUNTER_RELOAD_EN
        exp_o("c5_after", 5, 1'b1, 1'b0);
`else
        exp_o("c5_after", 0, 1'b0, 1'b0);
`endif
        cyc(1, 0, 8'd0, 1'b0); exp_o("rst2", 0, 1'b0, 1'b0);

        // Load 3, enable toggled: RUN holds while enable is low
        cyc(0, 1, 8'd3, 1'b0); exp_o("c3_load", 3, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("c3_e1", 2, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b0); exp_o("c3_e0", 2, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("c3_e1b", 1, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b0); exp_o("c3_e0b", 1, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("c3_done", 0, 1'b0, 1'b1);
        cyc(0, 0, 8'd0, 1'b0);
`ifdef DOWN_COUNTER_RELOAD_EN
        exp_o("c3_after", 3, 1'b1, 1'b0);
`else
        exp_o("c3_after", 0, 1'b0, 1'b0);
`endif
        cyc(1, 0, 8'd0, 1'b0);

        // IDLE ignores enable; no wrap below zero
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 8'd0, 1'b1); exp_o("idle_en", 0, 1'b0, 1'b0);
        end
        cyc(0, 1, 8'd0, 1'b1); exp_o("load0", 0, 1'b0, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("load0_after", 0, 1'b0, 1'b0);

        // Reset mid-count
        cyc(0, 1, 8'd200, 1'b1); exp_o("c200_load", 200, 1'b1, 1'b0);
        for (int i = 1; i <= 50; i++) cyc(0, 0, 8'd0, 1'b1);
        exp_o("c200_50", 150, 1'b1, 1'b0);
        cyc(1, 0, 8'd0, 1'b1); exp_o("c200_rst", 0, 1'b0, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("c200_after", 0, 1'b0, 1'b0);

        // Load honoured during DONE; done still seen that cycle
        cyc(0, 1, 8'd2, 1'b1); exp_o("ld_dn_2", 2, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("ld_dn_1", 1, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("ld_dn_done", 0, 1'b0, 1'b1);
        cyc(0, 1, 8'd7, 1'b1); exp_o("ld_dn_7", 7, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("ld_dn_6", 6, 1'b1, 1'b0);
        cyc(1, 0, 8'd0, 1'b0);

        // Reset during DONE suppresses whatever would follow
        cyc(0, 1, 8'd1, 1'b1); exp_o("rd_1", 1, 1'b1, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("rd_done", 0, 1'b0, 1'b1);
        cyc(1, 1, 8'd9, 1'b1); exp_o("rd_rst", 0, 1'b0, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("rd_after", 0, 1'b0, 1'b0);

`ifdef DOWN_COUNTER_RELOAD_EN
        // Auto-reload: 2,1,0,2,1,0 with done on each zero
        cyc(0, 1, 8'd2, 1'b1); exp_o("ar_2", 2, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 8'd0, 1'b1); exp_o("ar_1", 1, 1'b1, 1'b0);
            cyc(0, 0, 8'd0, 1'b1); exp_o("ar_0", 0, 1'b0, 1'b1);
            cyc(0, 0, 8'd0, 1'b1); exp_o("ar_re", 2, 1'b1, 1'b0);
        end
        cyc(0, 1, 8'd0, 1'b1); exp_o("ar_load0", 0, 1'b0, 1'b0);
        cyc(0, 0, 8'd0, 1'b1); exp_o("ar_idle", 0, 1'b0, 1'b0);
`endif

        cyc(0, 0, 8'd0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of load_value and out.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  count-down request, sampled each rising edge.
REQ-005 load  input  1  load strobe; captures load_value.
REQ-006 load_value  input  WIDTH  start value for the count.
REQ-007 out  output  WIDTH  current count, registered.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 zero  output  1  combinational, out == 0.
REQ-010 done  output  1  one-cycle pulse, high only in state DONE.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, RUN and DONE, all registered.
REQ-012 Load SHALL take priority over enable in every state, with one-cycle latency: out = load_value on the edge after load=1.
REQ-013 Load with load_value != 0 SHALL enter RUN; load with load_value == 0 SHALL enter IDLE with out = 0 and no done pulse.
REQ-014 Load SHALL also write an internal reload register with load_value.
REQ-015 In RUN with enable=1 and out > 1, out SHALL decrement by exactly 1 per cycle.
REQ-016 In RUN with enable=1 and out == 1, out SHALL become 0 and the state SHALL become DONE on the same edge.
REQ-017 In RUN with enable=0, out and state SHALL hold.
REQ-018 DONE SHALL last exactly one cycle; done=1 during that cycle; the next state depends on REQ-024/025 unless load=1.
REQ-019 In IDLE, enable SHALL have no effect: out holds, with no wrap from 0 to 2^WIDTH-1.
REQ-020 Load arriving during DONE SHALL be honoured per REQ-012/013; done SHALL still be high during that DONE cycle.

Reset
REQ-021 On reset=1 at a rising edge: state=IDLE, out=0, busy=0, done=0, reload register=0.
REQ-022 Reset SHALL override load and enable, including mid-count and during DONE; no done pulse SHALL follow a reset.

Configuration
REQ-023 Macro DOWN_COUNTER_RELOAD_EN SHALL select auto-reload.
REQ-024 With DOWN_COUNTER_RELOAD_EN defined, DONE SHALL exit to RUN with out = reload register.
- Exception: a reload register of 0 SHALL exit to IDLE.
REQ-025 Without DOWN_COUNTER_RELOAD_EN, DONE SHALL exit to IDLE with out = 0, and the reload register MAY be omitted.

Structure
REQ-026 A shared package down_counter_pkg SHALL hold:
- the state enum type (IDLE, RUN, DONE);
- the default width constant (8).
REQ-027 The block SHALL be a single module with no sub-modules; next-state/next-count logic and registers SHALL be kept separate.

Verification
REQ-028 reset=1 for 2 cycles with load=1, load_value=8'h55 -> out=0, busy=0, done=0, zero=1 throughout.
REQ-029 Load 5, then enable=1 continuously -> out 5,4,3,2,1,0 on consecutive edges; done=1 for exactly the one cycle after out reaches 0; then IDLE with busy=0.
REQ-030 Load 3, enable toggled 1,0,1,0,1 -> out 3,2,2,1,1,0; busy high until DONE.
REQ-031 In IDLE with out=0, enable=1 for 10 cycles -> out stays 0 with no done pulse; load 0 -> out=0, IDLE, no done.
REQ-032 Load 200, enable=1, assert reset after 50 decrements -> out=0 and IDLE on the next edge; no done pulse.
REQ-033 DOWN_COUNTER_RELOAD_EN defined, load 2, enable=1 -> out 2,1,0,2,1,0,... with done pulsing every third cycle.
- Load 7 asserted in the DONE cycle -> out=7 next and done remains one cycle.
